pc_update_unit: RTL

- Program-counter stage directly downstream of the pc-source selector in the multi-cycle RISC core.
- Consumes the 2-bit pc_src code and updates the PC register once per instruction, when the main control FSM asserts pc_write.
- Computes the sequential, branch and jump targets.
- Owns a circular return-address stack (RAS): calls push PC+4; the return code (pc_src=11) pops it.

---
 rtl/pc_update_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pc_update_unit.sv
// Program-counter update stage: sequential/branch/jump targets plus a circular
// return-address stack for call/return, all updated on the pc_write strobe.
module pc_update_unit #(
  parameter int               WIDTH     = 32,
  parameter int               RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pc_write,
  input  logic [1:0]                     pc_src,
  input  logic                           push_ra,
  input  logic [15:0]                    br_imm,
  input  logic [25:0]                    jmp_imm,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_plus4,
  output logic [WIDTH-1:0]               ras_top,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_RETURN = 2'b11;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] top_idx;

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] jmp_off;

  logic [WIDTH-1:0] pc_next;
  logic [PTR_W-1:0] sp_next;
  logic [CNT_W-1:0] count_next;
  logic             ovf_next;
  logic             unf_next;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic             do_pop;

  // Word offsets are sign-extended and scaled to bytes, so targets stay aligned.
  assign br_off  = {{(WIDTH-18){br_imm[15]}},  br_imm,  2'b00};
  assign jmp_off = {{(WIDTH-28){jmp_imm[25]}}, jmp_imm, 2'b00};

  assign pc_plus4  = pc + WIDTH'(4);
  assign top_idx   = sp - PTR_W'(1);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];
  assign do_pop    = pc_write && (pc_src == SRC_RETURN);

  always_comb begin
    pc_next    = pc;
    sp_next    = sp;
    count_next = ras_count;
    ovf_next   = ras_ovf;
    unf_next   = ras_unf;
    mem_we     = 1'b0;
    mem_waddr  = sp;

    if (pc_write) begin
      case (pc_src)
        SRC_SEQ:    pc_next = pc_plus4;
        SRC_BRANCH: pc_next = pc + br_off;
        SRC_JUMP:   pc_next = pc + jmp_off;
        default:    pc_next = ras_empty ? RESET_PC : ras_top;
      endcase

      if (do_pop && ras_empty)
        unf_next = 1'b1;

      // A combined return+call on a non-empty stack swaps the top in place.
      if (push_ra && do_pop && !ras_empty) begin
        mem_we    = 1'b1;
        mem_waddr = top_idx;
      end else if (push_ra) begin
        mem_we    = 1'b1;
        mem_waddr = sp;
        sp_next   = sp + PTR_W'(1);
        if (ras_full)
          ovf_next = 1'b1;
        else
          count_next = ras_count + CNT_W'(1);
      end else if (do_pop && !ras_empty) begin
        sp_next    = top_idx;
        count_next = ras_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      sp        <= '0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else begin
      pc        <= pc_next;
      sp        <= sp_next;
      ras_count <= count_next;
      ras_ovf   <= ovf_next;
      ras_unf   <= unf_next;
    end
  end

  // Storage is never cleared; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we)
      ras_mem[mem_waddr] <= pc_plus4;
  end

endmodule
